// File: rtl/lift_scheduler.sv
// Lift car request scheduler and motion sequencer using a collective (SCAN) policy; outputs registered, one-cycle request latency.
// Optional door-hold input is enabled by defining LIFT_DOOR_HOLD_EN.
module lift_scheduler #(
    parameter int NFLOORS    = 3,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 3,
    localparam int FW        = $clog2(NFLOORS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NFLOORS-1:0] req,
`ifdef LIFT_DOOR_HOLD_EN
    input  logic               door_hold,
`endif
    output logic               mv_up,
    output logic               mv_dn,
    output logic               door_open,
    output logic [FW-1:0]      floor,
    output logic [NFLOORS-1:0] at_floor,
    output logic [NFLOORS-1:0] pending,
    output logic               busy
);

    localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR} state_t;

    state_t             state_q, state_d;
    logic [FW-1:0]      floor_q, floor_d;
    logic [NFLOORS-1:0] at_floor_q, at_floor_d;
    logic [NFLOORS-1:0] pending_q, pending_d;
    logic               dir_up_q, dir_up_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic               mv_up_q, mv_up_d, mv_dn_q, mv_dn_d;
    logic               door_open_q, door_open_d, busy_q, busy_d;

    logic [NFLOORS-1:0] pend_raw, clr, arr_oh;
    logic               up_w, dn_w, door_restart, hold;

    function automatic logic any_above(input logic [NFLOORS-1:0] v, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NFLOORS; i++)
            if (i > int'(f) && v[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic any_below(input logic [NFLOORS-1:0] v, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NFLOORS; i++)
            if (i < int'(f) && v[i]) r = 1'b1;
        return r;
    endfunction

`ifdef LIFT_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        floor_d      = floor_q;
        dir_up_d     = dir_up_q;
        tcnt_d       = tcnt_q;
        dcnt_d       = dcnt_q;
        clr          = '0;
        arr_oh       = '0;
        // A call for the floor whose door is already open is absorbed, not latched.
        pend_raw     = pending_q | ((state_q == S_DOOR) ? (req & ~at_floor_q) : req);
        up_w         = any_above(pend_raw, floor_q);
        dn_w         = any_below(pend_raw, floor_q);
        door_restart = |(req & at_floor_q) | hold;

        case (state_q)
            S_IDLE: begin
                if (|(pend_raw & at_floor_q)) begin
                    clr     = at_floor_q;
                    state_d = S_DOOR;
                    dcnt_d  = '0;
                end else if (up_w && (dir_up_q || !dn_w)) begin
                    state_d  = S_MOVE_UP;
                    dir_up_d = 1'b1;
                    tcnt_d   = '0;
                end else if (dn_w) begin
                    state_d  = S_MOVE_DN;
                    dir_up_d = 1'b0;
                    tcnt_d   = '0;
                end
            end
            S_MOVE_UP, S_MOVE_DN: begin
                if (tcnt_q == TW'(TRAVEL_CYC - 1)) begin
                    tcnt_d = '0;
                    if (state_q == S_MOVE_UP) begin
                        floor_d = floor_q + FW'(1);
                        arr_oh  = at_floor_q << 1;
                    end else begin
                        floor_d = floor_q - FW'(1);
                        arr_oh  = at_floor_q >> 1;
                    end
                    if (|(pend_raw & arr_oh)) begin
                        clr     = arr_oh;
                        state_d = S_DOOR;
                        dcnt_d  = '0;
                    end else if ((state_q == S_MOVE_UP) ? !any_above(pend_raw, floor_d)
                                                        : !any_below(pend_raw, floor_d)) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_DOOR: begin
                if (door_restart) begin
                    dcnt_d = '0;
                end else if (dcnt_q == DW'(DOOR_CYC - 1)) begin
                    dcnt_d = '0;
                    if (up_w && (dir_up_q || !dn_w)) begin
                        state_d  = S_MOVE_UP;
                        dir_up_d = 1'b1;
                        tcnt_d   = '0;
                    end else if (dn_w) begin
                        state_d  = S_MOVE_DN;
                        dir_up_d = 1'b0;
                        tcnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        pending_d   = pend_raw & ~clr;
        at_floor_d  = {{(NFLOORS-1){1'b0}}, 1'b1} << floor_d;
        mv_up_d     = (state_d == S_MOVE_UP);
        mv_dn_d     = (state_d == S_MOVE_DN);
        door_open_d = (state_d == S_DOOR);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            floor_q     <= '0;
            at_floor_q  <= {{(NFLOORS-1){1'b0}}, 1'b1};
            pending_q   <= '0;
            dir_up_q    <= 1'b1;
            tcnt_q      <= '0;
            dcnt_q      <= '0;
            mv_up_q     <= 1'b0;
            mv_dn_q     <= 1'b0;
            door_open_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            at_floor_q  <= at_floor_d;
            pending_q   <= pending_d;
            dir_up_q    <= dir_up_d;
            tcnt_q      <= tcnt_d;
            dcnt_q      <= dcnt_d;
            mv_up_q     <= mv_up_d;
            mv_dn_q     <= mv_dn_d;
            door_open_q <= door_open_d;
            busy_q      <= busy_d;
        end
    end

    assign mv_up     = mv_up_q;
    assign mv_dn     = mv_dn_q;
    assign door_open = door_open_q;
    assign floor     = floor_q;
    assign at_floor  = at_floor_q;
    assign pending   = pending_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lift_scheduler.sv
// Bench for lift_scheduler: directed scenarios plus random calls, checked each cycle against a countdown-based car model.
module tb_lift_scheduler;

    localparam int NF = 3;
    localparam int TRAVEL_CYC = 4;
    localparam int DOOR_CYC = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NF-1:0] req = '0;
    logic          door_hold = 1'b0;
    logic          mv_up, mv_dn, door_open, busy;
    logic [1:0]    floor;
    logic [NF-1:0] at_floor, pending;

    int n_tests = 0;
    int n_fail = 0;
    int cnt_up, cnt_dn, cnt_door;

    // Model: car position, latched calls, motion direction (+1/-1/0) and countdowns.
    int          m_floor, m_dir, m_motion, m_door, m_trav;
    logic [NF-1:0] m_pend;

    lift_scheduler #(.NFLOORS(NF), .TRAVEL_CYC(TRAVEL_CYC), .DOOR_CYC(DOOR_CYC)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
`ifdef LIFT_DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .mv_up(mv_up),
        .mv_dn(mv_dn),
        .door_open(door_open),
        .floor(floor),
        .at_floor(at_floor),
        .pending(pending),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit want(input int d);
        bit r;
        r = 0;
        for (int i = 0; i < NF; i++)
            if (m_pend[i] && (i - m_floor) * d > 0) r = 1;
        return r;
    endfunction

    task automatic start(input int d);
        m_dir = d;
        m_motion = d;
        m_trav = TRAVEL_CYC;
    endtask

    task automatic serve();
        m_pend[m_floor] = 1'b0;
        m_door = DOOR_CYC;
        m_motion = 0;
    endtask

    task automatic model_step(input logic [NF-1:0] r, input logic h, input logic rst);
        if (rst) begin
            m_floor = 0; m_pend = '0; m_dir = 1; m_motion = 0; m_door = 0; m_trav = 0;
        end else if (m_door > 0) begin
            for (int i = 0; i < NF; i++) if (r[i] && i != m_floor) m_pend[i] = 1'b1;
            if (r[m_floor] || h) m_door = DOOR_CYC;
            else begin
                m_door--;
                if (m_door == 0) begin
                    if (want(m_dir)) start(m_dir);
                    else if (want(-m_dir)) start(-m_dir);
                end
            end
        end else if (m_motion != 0) begin
            m_pend |= r;
            m_trav--;
            if (m_trav == 0) begin
                m_floor += m_motion;
                if (m_pend[m_floor]) serve();
                else m_trav = TRAVEL_CYC;
            end
        end else begin
            m_pend |= r;
            if (m_pend[m_floor]) serve();
            else if (want(1) && (m_dir == 1 || !want(-1))) start(1);
            else if (want(-1)) start(-1);
        end
    endtask

    task automatic compare_all();
        check("floor", int'(floor), m_floor);
        check("at_floor", int'(at_floor), 1 << m_floor);
        check("pending", int'(pending), int'(m_pend));
        check("mv_up", int'(mv_up), int'(m_motion == 1));
        check("mv_dn", int'(mv_dn), int'(m_motion == -1));
        check("door_open", int'(door_open), int'(m_door > 0));
        check("busy", int'(busy), int'(m_door > 0 || m_motion != 0));
    endtask

    task automatic tick(input logic [NF-1:0] r, input logic h, input logic rst);
        logic h_eff;
        @(negedge clk);
        req = r;
        door_hold = h;
        reset = rst;
`ifdef LIFT_DOOR_HOLD_EN
        h_eff = h;
`else
        h_eff = 1'b0;
`endif
        @(posedge clk);
        model_step(r, h_eff, rst);
        #1;
        compare_all();
        if (mv_up) cnt_up++;
        if (mv_dn) cnt_dn++;
        if (door_open) cnt_door++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        cnt_up = 0; cnt_dn = 0; cnt_door = 0;
    endtask

    initial begin
        logic [NF-1:0] r;
        logic rst;
        clear_counts();

        // Reset state
        tick('0, 1'b0, 1'b1);
        tick('0, 1'b0, 1'b1);
        check("rst_floor", int'(floor), 0);
        check("rst_at_floor", int'(at_floor), 1);
        check("rst_busy", int'(busy), 0);

        // Call to top floor: passes floor 1 without stopping
        clear_counts();
        tick(3'b100, 1'b0, 1'b0);
        idle(15);
        check("t2_up_cycles", cnt_up, 8);
        check("t2_door_cycles", cnt_door, 3);
        check("t2_floor", int'(floor), 2);
        check("t2_pending", int'(pending), 0);

        // Call at current floor: door only
        tick('0, 1'b0, 1'b1);
        clear_counts();
        tick(3'b001, 1'b0, 1'b0);
        idle(6);
        check("t3_door_cycles", cnt_door, 3);
        check("t3_move_cycles", cnt_up + cnt_dn, 0);

        // Intermediate call two cycles before arrival at floor 1
        tick('0, 1'b0, 1'b1);
        clear_counts();
        tick(3'b100, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0);
        tick(3'b010, 1'b0, 1'b0);
        idle(9);
        check("t4_up_cycles", cnt_up, 8);
        check("t4_floor", int'(floor), 2);
        check("t4_door_at_top", int'(door_open), 1);

        // Calls below while door open at top: reverse straight from DOOR
        clear_counts();
        tick(3'b011, 1'b0, 1'b0);
        idle(30);
        check("t5_dn_cycles", cnt_dn, 8);
        check("t5_door_cycles", cnt_door, 8);
        check("t5_floor", int'(floor), 0);
        check("t5_busy", int'(busy), 0);

        // Reset mid-move
        tick(3'b100, 1'b0, 1'b0);
        idle(2);
        tick('0, 1'b0, 1'b1);
        check("t6_floor", int'(floor), 0);
        check("t6_pending", int'(pending), 0);
        check("t6_mv_up", int'(mv_up), 0);

`ifdef LIFT_DOOR_HOLD_EN
        clear_counts();
        tick(3'b001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick('0, 1'b1, 1'b0);
        idle(6);
        check("t6_hold_door_cycles", cnt_door, 8);
`endif

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 5) == 0) ? NF'($urandom_range(0, 7)) : '0;
            rst = ($urandom_range(0, 399) == 0);
            tick(r, 1'(($urandom_range(0, 7) == 0)), rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
